// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: load-type encodings and well-known register indices.
package mips_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [2:0] {
    LOAD_LW  = 3'b000,
    LOAD_LB  = 3'b001,
    LOAD_LBU = 3'b010,
    LOAD_LH  = 3'b011,
    LOAD_LHU = 3'b100
  } load_type_e;

endpackage

// File: rtl/load_align.sv
// Big-endian load alignment: picks the addressed byte/halfword, extends it, and flags misalignment.
module load_align
  import mips_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            addr,
  input  logic [2:0]            load_type,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr[1] ? word[15:0] : word[31:16];
  end

  // Reserved encodings fall into the default arm and behave as LW.
  always_comb begin
    data       = word;
    misaligned = (addr != 2'd0);
    case (load_type)
      LOAD_LB: begin
        data       = {{24{byte_sel[7]}}, byte_sel};
        misaligned = 1'b0;
      end
      LOAD_LBU: begin
        data       = {24'd0, byte_sel};
        misaligned = 1'b0;
      end
      LOAD_LH: begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      LOAD_LHU: begin
        data       = {16'd0, half_sel};
        misaligned = addr[0];
      end
      default: begin
        data       = word;
        misaligned = (addr != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register plus writeback select, misaligned-load detection and retire counter.
// Define WB_BYPASS_EN to add combinational rs/rt forwarding ports for the ID stage.
module writeback_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  memValid,
  input  logic                  memRegWrite,
  input  logic [4:0]            memWriteRegister,
  input  logic [DATA_WIDTH-1:0] memAluResult,
  input  logic [DATA_WIDTH-1:0] memReadData,
  input  logic                  memToReg,
  input  logic [2:0]            memLoadType,
  input  logic                  memLink,
  input  logic [DATA_WIDTH-1:0] memPcPlus4,
`ifdef WB_BYPASS_EN
  input  logic [4:0]            rsAddr,
  input  logic [4:0]            rtAddr,
  output logic                  rsHit,
  output logic                  rtHit,
  output logic [DATA_WIDTH-1:0] rsData,
  output logic [DATA_WIDTH-1:0] rtData,
`endif
  output logic                  regWrite,
  output logic [4:0]            writeRegister,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  wbValid,
  output logic                  alignError,
  output logic [31:0]           retireCount
);

  logic                  valid;
  logic                  reg_write;
  logic [4:0]            dest;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  mem_to_reg;
  logic [2:0]            load_type;
  logic                  link;
  logic [DATA_WIDTH-1:0] pc_plus4;

  logic [DATA_WIDTH-1:0] load_data;
  logic                  misaligned;

  // Flush only kills valid; the payload fields simply hold.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      valid      <= 1'b0;
      reg_write  <= 1'b0;
      dest       <= REG_ZERO;
      alu_result <= '0;
      read_data  <= '0;
      mem_to_reg <= 1'b0;
      load_type  <= LOAD_LW;
      link       <= 1'b0;
      pc_plus4   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!stall) begin
      valid      <= memValid;
      reg_write  <= memRegWrite;
      dest       <= memWriteRegister;
      alu_result <= memAluResult;
      read_data  <= memReadData;
      mem_to_reg <= memToReg;
      load_type  <= memLoadType;
      link       <= memLink;
      pc_plus4   <= memPcPlus4;
    end
  end

  // An instruction retires as it leaves the stage, so a stalled one counts only once.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      retireCount <= 32'd0;
    end else if (valid && !stall) begin
      retireCount <= retireCount + 32'd1;
    end
  end

  load_align u_load_align (
    .word       (read_data),
    .addr       (alu_result[1:0]),
    .load_type  (load_type),
    .data       (load_data),
    .misaligned (misaligned)
  );

  always_comb begin
    wbValid    = valid;
    alignError = valid & mem_to_reg & misaligned;
    if (link) begin
      writeData     = pc_plus4;
      writeRegister = LINK_REG;
    end else if (mem_to_reg) begin
      writeData     = load_data;
      writeRegister = dest;
    end else begin
      writeData     = alu_result;
      writeRegister = dest;
    end
    regWrite = valid & reg_write & ~alignError & (writeRegister != REG_ZERO);
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    rsHit  = regWrite & (writeRegister == rsAddr);
    rtHit  = regWrite & (writeRegister == rtAddr);
    rsData = rsHit ? writeData : '0;
    rtData = rtHit ? writeData : '0;
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: reset, load alignment, link, stall/flush and retire counting.
module tb_writeback_stage;

  logic        clock;
  logic        resetN;
  logic        stall;
  logic        flush;
  logic        memValid;
  logic        memRegWrite;
  logic [4:0]  memWriteRegister;
  logic [31:0] memAluResult;
  logic [31:0] memReadData;
  logic        memToReg;
  logic [2:0]  memLoadType;
  logic        memLink;
  logic [31:0] memPcPlus4;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic        wbValid;
  logic        alignError;
  logic [31:0] retireCount;
`ifdef WB_BYPASS_EN
  logic [4:0]  rsAddr;
  logic [4:0]  rtAddr;
  logic        rsHit;
  logic        rtHit;
  logic [31:0] rsData;
  logic [31:0] rtData;
`endif

  int errors = 0;
  int checks = 0;

  writeback_stage dut (
    .clock            (clock),
    .resetN           (resetN),
    .stall            (stall),
    .flush            (flush),
    .memValid         (memValid),
    .memRegWrite      (memRegWrite),
    .memWriteRegister (memWriteRegister),
    .memAluResult     (memAluResult),
    .memReadData      (memReadData),
    .memToReg         (memToReg),
    .memLoadType      (memLoadType),
    .memLink          (memLink),
    .memPcPlus4       (memPcPlus4),
`ifdef WB_BYPASS_EN
    .rsAddr           (rsAddr),
    .rtAddr           (rtAddr),
    .rsHit            (rsHit),
    .rtHit            (rtHit),
    .rsData           (rsData),
    .rtData           (rtData),
`endif
    .regWrite         (regWrite),
    .writeRegister    (writeRegister),
    .writeData        (writeData),
    .wbValid          (wbValid),
    .alignError       (alignError),
    .retireCount      (retireCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic rw, input logic [4:0] dest,
                               input logic [31:0] alu, input logic [31:0] rdata, input logic m2r,
                               input logic [2:0] ltype, input logic lnk, input logic [31:0] pc);
    memValid         = valid;
    memRegWrite      = rw;
    memWriteRegister = dest;
    memAluResult     = alu;
    memReadData      = rdata;
    memToReg         = m2r;
    memLoadType      = ltype;
    memLink          = lnk;
    memPcPlus4       = pc;
  endtask

  // Inputs change on the falling edge; each @(negedge) lets exactly one rising edge capture them.
  initial begin
    resetN = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
`ifdef WB_BYPASS_EN
    rsAddr = 5'd0;
    rtAddr = 5'd0;
`endif
    applyStimulus(1, 1, 5'd3, 32'h12345678, 32'h0, 0, 3'b000, 0, 32'h0);
    repeat (2) @(negedge clock);
    checkOutput("reset_regWrite", {31'd0, regWrite}, 32'd0);
    checkOutput("reset_wbValid", {31'd0, wbValid}, 32'd0);
    checkOutput("reset_alignError", {31'd0, alignError}, 32'd0);
    checkOutput("reset_writeRegister", {27'd0, writeRegister}, 32'd0);
    checkOutput("reset_writeData", writeData, 32'd0);
    checkOutput("reset_retireCount", retireCount, 32'd0);

    resetN = 1'b1;
    @(negedge clock);
    checkOutput("first_regWrite", {31'd0, regWrite}, 32'd1);
    checkOutput("first_writeRegister", {27'd0, writeRegister}, 32'd3);
    checkOutput("first_writeData", writeData, 32'h12345678);
    checkOutput("first_retireCount", retireCount, 32'd0);

    applyStimulus(1, 1, 5'd4, 32'h00001001, 32'h8081F2F3, 1, 3'b001, 0, 32'h0);
    @(negedge clock);
    checkOutput("lb_writeData", writeData, 32'hFFFFFF81);
    checkOutput("lb_regWrite", {31'd0, regWrite}, 32'd1);
    checkOutput("lb_alignError", {31'd0, alignError}, 32'd0);
    checkOutput("lb_retireCount", retireCount, 32'd1);

    applyStimulus(1, 1, 5'd4, 32'h00001001, 32'h8081F2F3, 1, 3'b010, 0, 32'h0);
    @(negedge clock);
    checkOutput("lbu_writeData", writeData, 32'h00000081);

    applyStimulus(1, 1, 5'd4, 32'h00001002, 32'h8081F2F3, 1, 3'b011, 0, 32'h0);
    @(negedge clock);
    checkOutput("lh_writeData", writeData, 32'hFFFFF2F3);
    checkOutput("lh_alignError", {31'd0, alignError}, 32'd0);

    applyStimulus(1, 1, 5'd4, 32'h00001000, 32'h8081F2F3, 1, 3'b100, 0, 32'h0);
    @(negedge clock);
    checkOutput("lhu_writeData", writeData, 32'h00008081);
    checkOutput("lhu_retireCount", retireCount, 32'd4);

    applyStimulus(1, 1, 5'd5, 32'h00001003, 32'h8081F2F3, 1, 3'b011, 0, 32'h0);
    @(negedge clock);
    checkOutput("lh_odd_alignError", {31'd0, alignError}, 32'd1);
    checkOutput("lh_odd_regWrite", {31'd0, regWrite}, 32'd0);

    applyStimulus(1, 1, 5'd5, 32'h00001002, 32'h8081F2F3, 1, 3'b000, 0, 32'h0);
    @(negedge clock);
    checkOutput("lw_mis_alignError", {31'd0, alignError}, 32'd1);
    checkOutput("lw_mis_regWrite", {31'd0, regWrite}, 32'd0);
    checkOutput("lw_mis_retireCount", retireCount, 32'd6);

    applyStimulus(1, 1, 5'd6, 32'h00001004, 32'hCAFEBABE, 1, 3'b111, 0, 32'h0);
    @(negedge clock);
    checkOutput("reserved_writeData", writeData, 32'hCAFEBABE);
    checkOutput("reserved_regWrite", {31'd0, regWrite}, 32'd1);

    applyStimulus(1, 1, 5'd0, 32'h00000005, 32'h0, 0, 3'b000, 0, 32'h0);
    @(negedge clock);
    checkOutput("zero_regWrite", {31'd0, regWrite}, 32'd0);
    checkOutput("zero_writeData", writeData, 32'd5);

    applyStimulus(1, 1, 5'd8, 32'h00000000, 32'h11111111, 1, 3'b000, 1, 32'h00400010);
    @(negedge clock);
    checkOutput("link_writeRegister", {27'd0, writeRegister}, 32'd31);
    checkOutput("link_writeData", writeData, 32'h00400010);
    checkOutput("link_regWrite", {31'd0, regWrite}, 32'd1);
    checkOutput("link_retireCount", retireCount, 32'd9);

    stall = 1'b1;
    applyStimulus(1, 1, 5'd9, 32'h0000DEAD, 32'h0, 0, 3'b000, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("stall_writeData", writeData, 32'h00400010);
      checkOutput("stall_writeRegister", {27'd0, writeRegister}, 32'd31);
      checkOutput("stall_retireCount", retireCount, 32'd9);
    end
    stall = 1'b0;
    @(negedge clock);
    checkOutput("unstall_writeData", writeData, 32'h0000DEAD);
    checkOutput("unstall_writeRegister", {27'd0, writeRegister}, 32'd9);
    checkOutput("unstall_retireCount", retireCount, 32'd10);

    stall = 1'b1;
    flush = 1'b1;
    @(negedge clock);
    checkOutput("flush_wbValid", {31'd0, wbValid}, 32'd0);
    checkOutput("flush_regWrite", {31'd0, regWrite}, 32'd0);
    checkOutput("flush_retireCount", retireCount, 32'd10);
    stall = 1'b0;
    flush = 1'b0;
    applyStimulus(1, 1, 5'd10, 32'h0000000A, 32'h0, 0, 3'b000, 0, 32'h0);
    @(negedge clock);
    checkOutput("post_flush_wbValid", {31'd0, wbValid}, 32'd1);
    checkOutput("post_flush_retireCount", retireCount, 32'd10);

    applyStimulus(0, 1, 5'd11, 32'h00000077, 32'h0, 0, 3'b000, 0, 32'h0);
    @(negedge clock);
    checkOutput("invalid_regWrite", {31'd0, regWrite}, 32'd0);
    checkOutput("invalid_writeData", writeData, 32'h00000077);
    checkOutput("invalid_writeRegister", {27'd0, writeRegister}, 32'd11);
    checkOutput("invalid_retireCount", retireCount, 32'd11);

    applyStimulus(1, 1, 5'd12, 32'h00000088, 32'h0, 0, 3'b000, 0, 32'h0);
    @(negedge clock);
    checkOutput("after_invalid_retireCount", retireCount, 32'd11);

    force dut.retireCount = 32'hFFFFFFFF;
    #1;
    release dut.retireCount;
    @(negedge clock);
    checkOutput("wrap_retireCount", retireCount, 32'd0);

`ifdef WB_BYPASS_EN
    applyStimulus(1, 1, 5'd17, 32'd20, 32'h0, 0, 3'b000, 0, 32'h0);
    rsAddr = 5'd17;
    rtAddr = 5'd0;
    @(negedge clock);
    checkOutput("bypass_rsHit", {31'd0, rsHit}, 32'd1);
    checkOutput("bypass_rsData", rsData, 32'd20);
    checkOutput("bypass_rtHit", {31'd0, rtHit}, 32'd0);
    checkOutput("bypass_rtData", rtData, 32'd0);
`endif

    applyStimulus(1, 1, 5'd13, 32'h00000099, 32'h0, 0, 3'b000, 0, 32'h0);
    @(negedge clock);
    stall  = 1'b1;
    flush  = 1'b1;
    resetN = 1'b0;
    @(negedge clock);
    checkOutput("midreset_wbValid", {31'd0, wbValid}, 32'd0);
    checkOutput("midreset_writeData", writeData, 32'd0);
    checkOutput("midreset_writeRegister", {27'd0, writeRegister}, 32'd0);
    checkOutput("midreset_retireCount", retireCount, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the MIPS datapath.
- Captures MEM-stage results and aligns and extends load data.
- Selects ALU, load or link data, then drives the register file write port (regWrite, writeRegister, writeData).
- Also flags misaligned loads and counts retired instructions.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 supported.
- LINK_REG, 31, register index written by link instructions.

Ports:
- clock  input  1  system clock
- resetN  input  1  synchronous reset, active low
- stall  input  1  hold the stage contents
- flush  input  1  invalidate the instruction being captured
- memValid  input  1  MEM stage holds a real instruction
- memRegWrite  input  1  instruction writes a register
- memWriteRegister  input  5  destination register
- memAluResult  input  32  ALU result / load address
- memReadData  input  32  raw data-memory word
- memToReg  input  1  1 = load data, 0 = ALU result
- memLoadType  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU
- memLink  input  1  link instruction (jal/jalr)
- memPcPlus4  input  32  PC+4 of the instruction
- regWrite  output  1  register file write enable
- writeRegister  output  5  register file write address
- writeData  output  32  register file write data
- wbValid  output  1  stage holds a valid instruction
- alignError  output  1  misaligned load in stage
- retireCount  output  32  retired instruction count

Behaviour:
- Reset (resetN=0 at a posedge):
  - Clears every stage register: valid, regWrite, dest, aluResult, readData, memToReg, loadType, link, pcPlus4.
  - Clears retireCount.
  - Outputs then read: regWrite=0, writeRegister=0, writeData=0, wbValid=0, alignError=0, retireCount=0.
  - Reset mid-stall or mid-flush still clears everything.
- Capture priority at each posedge:
  - flush=1: valid<=0; other fields don't-care, implementation holds them. flush wins over stall.
  - else stall=1: all fields hold.
  - else: all fields load from mem* inputs; valid<=memValid.
- Latency: one cycle, MEM inputs to write port. Outputs come only from stage registers plus combinational alignment; no mem* input reaches an output combinationally.
- Load alignment (big-endian, addr = stored aluResult[1:0]):
  - LB/LBU byte select: addr 0 → bits 31:24, 1 → 23:16, 2 → 15:8, 3 → 7:0.
  - LB sign-extends the byte; LBU zero-extends it.
  - LH/LHU: addr[1]=0 selects bits 31:16, addr[1]=1 selects bits 15:0; LH sign-extends, LHU zero-extends.
  - LW: whole word.
  - loadType 101–111: treated as LW.
- alignError = valid & memToReg & (LW/reserved with addr≠0, or LH/LHU with addr[0]=1). When asserted, regWrite is forced to 0.
- Data select:
  - link=1: writeData=pcPlus4, writeRegister=LINK_REG.
  - else memToReg=1: aligned load data.
  - else: aluResult.
  - link wins over memToReg.
- regWrite = valid & storedRegWrite & ~alignError & (writeRegister≠0). Writes to $zero are suppressed here.
- When valid=0: writeRegister and writeData still show the stored fields, but regWrite=0.
- retireCount:
  - Increments by 1 on each posedge where wbValid=1 and stall=0. A stalled instruction counts once, when it leaves the stage.
  - Misaligned instructions count.
  - Wraps from 0xFFFFFFFF to 0.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: adds inputs rsAddr[4:0], rtAddr[4:0] and outputs rsHit, rtHit, rsData[31:0], rtData[31:0], all combinational.
  - rsHit = regWrite & (writeRegister==rsAddr); rtHit likewise.
  - rsData/rtData = writeData when the hit flag is 1, else 0.
  - Lets ID forward around the register file's non-write-through read.
- Undefined: these ports are absent; the stage is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - load-type constants: LOAD_LW, LOAD_LB, LOAD_LBU, LOAD_LH, LOAD_LHU.
  - REG_ZERO=0 and REG_RA=31.
  - DATA_WIDTH=32.
- One natural sub-module: load_align, purely combinational. Inputs: word, addr[1:0], loadType. Outputs: data, misaligned.
- Stage registers, select mux and counter stay in writeback_stage.

Test Plan:
- Reset: resetN=0 for 2 cycles with memValid=1 → regWrite=0, wbValid=0, retireCount=0; first valid capture after release is written next cycle.
- Loads: memReadData=0x8081F2F3, memToReg=1, in four consecutive cycles:
  - LB addr 1 → writeData=0xFFFFFF81.
  - LBU addr 1 → 0x00000081.
  - LH addr 2 → 0xFFFFF2F3.
  - LHU addr 0 → 0x00008081.
- Misaligned and $zero: LW addr 2 → alignError=1, regWrite=0; ALU write to reg 0 with data 5 → regWrite=0.
- Link: memLink=1, memToReg=1, memPcPlus4=0x00400010, dest=8 → writeRegister=31, writeData=0x00400010, regWrite=1.
- Stall/flush/counter:
  - Stall 3 cycles → outputs hold; retireCount rises by 1 only on release.
  - stall=1 with flush=1 → wbValid=0 next cycle.
  - Preload path: 0xFFFFFFFF retirements → retireCount wraps to 0.
- Bypass (WB_BYPASS_EN): regWrite to reg 17, data 20, rsAddr=17, rtAddr=0 → rsHit=1, rsData=20, rtHit=0, rtData=0.
